ballot_casting_unit: RTL and testbench

Downstream consumer of the voter-ID database stage in the EVM. When the database asserts `write` with a validated voter and address, this block arms the candidate keypad. It accepts exactly one vote from that voter, rejecting double voting and inactive voters. It keeps per-candidate tallies and serves them on a registered readout port in result mode.

---
 rtl/evm_pkg.sv | 30 +++
 rtl/evm_onehot_check.sv | 38 +++
 rtl/ballot_casting_unit.sv | 195 +++++++++++++++++++
 tb/tb_ballot_casting_unit.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/evm_pkg.sv
// ----------------------------------------------------------------------------
// evm_pkg
// Shared definitions for the EVM ballot stage: the casting FSM state
// encoding, the meaning of the mode input, the voter-ID width and the
// largest candidate count the tally bank and readout select can address.
// No ports; imported by the ballot casting unit and its one-hot checker.
// ----------------------------------------------------------------------------
package evm_pkg;

    // Casting flow: wait for a validated voter, accept one press, then wait
    // for the keypad to be released before the next voter can be armed.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RELEASE = 2'd2
    } state_e;

    // The mode input: voting enables casting, result enables the readout.
    localparam logic MODE_VOTING = 1'b1;
    localparam logic MODE_RESULT = 1'b0;

    // Voter IDs coming from the database stage are this wide.
    localparam int VOTER_ID_W = 5;

    // The readout select is three bits, so the tally bank is always sized
    // for eight entries; entries at or above NUM_CAND are never written.
    localparam int CAND_MAX   = 8;
    localparam int CAND_IDX_W = 3;

endpackage

// File: rtl/evm_onehot_check.sv
// ----------------------------------------------------------------------------
// evm_onehot_check
// Combinational check that the candidate keypad shows exactly one pressed
// button, and the index of that button.
// Ports:
//   cand_btn_i  in  NUM_CAND    raw button levels, active-high
//   valid_o     out 1           exactly one button is pressed
//   idx_o       out CAND_IDX_W  index of the pressed button (meaningful only
//                               when valid_o is high)
// ----------------------------------------------------------------------------
module evm_onehot_check
    import evm_pkg::*;
#(
    parameter int NUM_CAND = 4
) (
    input  logic [NUM_CAND-1:0]   cand_btn_i,
    output logic                  valid_o,
    output logic [CAND_IDX_W-1:0] idx_o
);

    int pressCount;

    // Count the pressed buttons and remember the index of the last one seen.
    // With exactly one button down that index is the pressed candidate; with
    // zero or several buttons down the press is not valid and idx_o is moot.
    always_comb begin
        pressCount = 0;
        idx_o      = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (cand_btn_i[i]) begin
                pressCount = pressCount + 1;
                idx_o      = CAND_IDX_W'(i);
            end
        end
        valid_o = (pressCount == 1);
    end

endmodule

// File: rtl/ballot_casting_unit.sv
// ----------------------------------------------------------------------------
// ballot_casting_unit
// Arms the candidate keypad for one validated voter at a time, records
// exactly one vote per voter address, keeps saturating per-candidate and
// total tallies, and serves a registered tally readout in result mode.
// Ports:
//   clk                  in  1           clock, rising edge
//   rst_n                in  1           asynchronous reset, active low
//   mode                 in  1           1 = voting, 0 = result
//   write                in  1           validated-voter pulse from database
//   valid_voter_address  in  ADDR_W      bitmap index of that voter
//   valid_voter          in  VOTER_ID_W  voter ID
//   cand_btn             in  NUM_CAND    candidate buttons, level
//   result_sel           in  3           candidate index for readout
//   armed                out 1           keypad enabled
//   vote_accepted        out 1           pulse: vote recorded
//   vote_rejected        out 1           pulse: address already voted
//   timeout              out 1           pulse: armed voter timed out
//   last_voter           out VOTER_ID_W  ID of most recent accepted voter
//   result_count         out COUNT_W     registered tally of result_sel
//   total_votes          out COUNT_W     saturating sum of accepted votes
// ----------------------------------------------------------------------------
module ballot_casting_unit
    import evm_pkg::*;
#(
    parameter int NUM_CAND       = 4,
    parameter int COUNT_W        = 8,
    parameter int ADDR_W         = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic                  write,
    input  logic [ADDR_W-1:0]     valid_voter_address,
    input  logic [VOTER_ID_W-1:0] valid_voter,
    input  logic [NUM_CAND-1:0]   cand_btn,
    input  logic [CAND_IDX_W-1:0] result_sel,
    output logic                  armed,
    output logic                  vote_accepted,
    output logic                  vote_rejected,
    output logic                  timeout,
    output logic [VOTER_ID_W-1:0] last_voter,
    output logic [COUNT_W-1:0]    result_count,
    output logic [COUNT_W-1:0]    total_votes
);

    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e                  state_q, state_d;
    logic [TIMER_W-1:0]      timer_q, timer_d;
    logic [ADDR_W-1:0]       voterAddr_q, voterAddr_d;
    logic [VOTER_ID_W-1:0]   voterId_q, voterId_d;
    logic                    accepted_q, accepted_d;
    logic                    rejected_q, rejected_d;
    logic                    timeout_q, timeout_d;
    logic                    recordVote;

    logic [VOTER_ID_W-1:0]   lastVoter_q;
    logic [COUNT_W-1:0]      tally_q [CAND_MAX];
    logic [COUNT_W-1:0]      total_q;
    logic [COUNT_W-1:0]      resultCount_q;
    logic [(1<<ADDR_W)-1:0]  voted_q;

    logic                    pressValid;
    logic [CAND_IDX_W-1:0]   pressIdx;

    evm_onehot_check #(
        .NUM_CAND (NUM_CAND)
    ) u_onehot (
        .cand_btn_i (cand_btn),
        .valid_o    (pressValid),
        .idx_o      (pressIdx)
    );

    // Casting FSM next-state logic. A write is honoured only from IDLE in
    // voting mode; an address already in the bitmap is bounced with a reject
    // pulse. Once armed, leaving voting mode abandons the voter silently, a
    // clean one-hot press records the vote, and otherwise the timer runs
    // until the voter is dropped with a timeout pulse (bitmap untouched, so
    // they may come back). After a vote the keypad must go fully quiet before
    // IDLE, so a held key cannot vote for the next person.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        voterAddr_d = voterAddr_q;
        voterId_d   = voterId_q;
        accepted_d  = 1'b0;
        rejected_d  = 1'b0;
        timeout_d   = 1'b0;
        recordVote  = 1'b0;
        case (state_q)
            IDLE: begin
                if (write && mode == MODE_VOTING) begin
                    if (voted_q[valid_voter_address]) begin
                        rejected_d = 1'b1;
                    end else begin
                        voterAddr_d = valid_voter_address;
                        voterId_d   = valid_voter;
                        timer_d     = '0;
                        state_d     = ARMED;
                    end
                end
            end
            ARMED: begin
                if (mode == MODE_RESULT) begin
                    state_d = IDLE;
                end else if (pressValid) begin
                    recordVote = 1'b1;
                    accepted_d = 1'b1;
                    state_d    = RELEASE;
                end else if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RELEASE: begin
                if (cand_btn == '0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, the pending voter captured at arming, the idle timer and
    // the registered one-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            voterAddr_q <= '0;
            voterId_q   <= '0;
            accepted_q  <= 1'b0;
            rejected_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            voterAddr_q <= voterAddr_d;
            voterId_q   <= voterId_d;
            accepted_q  <= accepted_d;
            rejected_q  <= rejected_d;
            timeout_q   <= timeout_d;
        end
    end

    // Vote recording: bump the chosen candidate and the grand total, both
    // holding at all-ones rather than wrapping, mark the voter's address as
    // used and publish the voter's ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CAND_MAX; i++) begin
                tally_q[i] <= '0;
            end
            total_q     <= '0;
            voted_q     <= '0;
            lastVoter_q <= '0;
        end else if (recordVote) begin
            if (tally_q[pressIdx] != '1) begin
                tally_q[pressIdx] <= tally_q[pressIdx] + 1'b1;
            end
            if (total_q != '1) begin
                total_q <= total_q + 1'b1;
            end
            voted_q[voterAddr_q] <= 1'b1;
            lastVoter_q          <= voterId_q;
        end
    end

    // Registered readout. Only result mode exposes a tally; a select beyond
    // the configured candidates, or voting mode, reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resultCount_q <= '0;
        end else if (mode == MODE_RESULT && int'(result_sel) < NUM_CAND) begin
            resultCount_q <= tally_q[result_sel];
        end else begin
            resultCount_q <= '0;
        end
    end

    assign armed         = (state_q == ARMED);
    assign vote_accepted = accepted_q;
    assign vote_rejected = rejected_q;
    assign timeout       = timeout_q;
    assign last_voter    = lastVoter_q;
    assign result_count  = resultCount_q;
    assign total_votes   = total_q;

endmodule

// File: tb/tb_ballot_casting_unit.sv
// ----------------------------------------------------------------------------
// tb_ballot_casting_unit
// Directed stimulus for the ballot casting unit with a behavioural model of
// the voting rules checked against every DUT output on every cycle, plus
// hand-computed literal checks at the key points of each scenario.
// ----------------------------------------------------------------------------
module tb_ballot_casting_unit;

    localparam int NUM_CAND       = 4;
    localparam int COUNT_W        = 8;
    localparam int ADDR_W         = 9;
    localparam int TIMEOUT_CYCLES = 20;
    localparam int MAX_COUNT      = (1 << COUNT_W) - 1;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                mode = 1'b1;
    logic                write = 1'b0;
    logic [ADDR_W-1:0]   valid_voter_address = '0;
    logic [4:0]          valid_voter = '0;
    logic [NUM_CAND-1:0] cand_btn = '0;
    logic [2:0]          result_sel = '0;

    logic                armed;
    logic                vote_accepted;
    logic                vote_rejected;
    logic                timeout;
    logic [4:0]          last_voter;
    logic [COUNT_W-1:0]  result_count;
    logic [COUNT_W-1:0]  total_votes;

    int testsRun = 0;
    int testsFailed = 0;
    bit compareOn = 1'b0;

    // Behavioural view of the ballot: who is currently allowed to vote, how
    // long they have been standing there, whether we are waiting for hands
    // off the keypad, which addresses have voted, and the running counts.
    bit keypadLive = 1'b0;
    bit waitRelease = 1'b0;
    int liveEdges = 0;
    int pendAddr = 0;
    int pendId = 0;
    bit voted [1<<ADDR_W];
    int tally [8];
    int total = 0;
    int lastVoter = 0;
    int expResult = 0;
    bit expAccepted = 1'b0;
    bit expRejected = 1'b0;
    bit expTimeout = 1'b0;
    int pressCount;
    int pressIdx;

    always #5 clk = ~clk;

    ballot_casting_unit #(
        .NUM_CAND       (NUM_CAND),
        .COUNT_W        (COUNT_W),
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .mode                (mode),
        .write               (write),
        .valid_voter_address (valid_voter_address),
        .valid_voter         (valid_voter),
        .cand_btn            (cand_btn),
        .result_sel          (result_sel),
        .armed               (armed),
        .vote_accepted       (vote_accepted),
        .vote_rejected       (vote_rejected),
        .timeout             (timeout),
        .last_voter          (last_voter),
        .result_count        (result_count),
        .total_votes         (total_votes)
    );

    // Model of the voting rules, advanced once per clock with the inputs the
    // DUT sees at that edge. Readout uses the counts as they stood before any
    // vote recorded at the same edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keypadLive  = 1'b0;
            waitRelease = 1'b0;
            liveEdges   = 0;
            for (int i = 0; i < (1 << ADDR_W); i++) voted[i] = 1'b0;
            for (int i = 0; i < 8; i++) tally[i] = 0;
            total       = 0;
            lastVoter   = 0;
            expResult   = 0;
            expAccepted = 1'b0;
            expRejected = 1'b0;
            expTimeout  = 1'b0;
        end else begin
            expResult   = (mode == 1'b0 && int'(result_sel) < NUM_CAND) ? tally[result_sel] : 0;
            expAccepted = 1'b0;
            expRejected = 1'b0;
            expTimeout  = 1'b0;
            pressCount  = 0;
            pressIdx    = 0;
            for (int i = 0; i < NUM_CAND; i++) begin
                if (cand_btn[i]) begin
                    pressCount++;
                    pressIdx = i;
                end
            end
            if (keypadLive) begin
                if (mode == 1'b0) begin
                    keypadLive = 1'b0;
                end else if (pressCount == 1) begin
                    if (tally[pressIdx] < MAX_COUNT) tally[pressIdx]++;
                    if (total < MAX_COUNT) total++;
                    voted[pendAddr] = 1'b1;
                    lastVoter       = pendId;
                    expAccepted     = 1'b1;
                    keypadLive      = 1'b0;
                    waitRelease     = 1'b1;
                end else begin
                    liveEdges++;
                    if (liveEdges == TIMEOUT_CYCLES) begin
                        expTimeout = 1'b1;
                        keypadLive = 1'b0;
                    end
                end
            end else if (waitRelease) begin
                if (pressCount == 0) waitRelease = 1'b0;
            end else if (write && mode) begin
                if (voted[valid_voter_address]) begin
                    expRejected = 1'b1;
                end else begin
                    keypadLive = 1'b1;
                    liveEdges  = 0;
                    pendAddr   = int'(valid_voter_address);
                    pendId     = int'(valid_voter);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
        end
    endtask

    // Every cycle, compare all DUT outputs against the model, well clear of
    // the clock edge.
    always @(posedge clk) begin
        #3;
        if (compareOn) begin
            checkOutput("armed", 32'(armed), 32'(keypadLive));
            checkOutput("vote_accepted", 32'(vote_accepted), 32'(expAccepted));
            checkOutput("vote_rejected", 32'(vote_rejected), 32'(expRejected));
            checkOutput("timeout", 32'(timeout), 32'(expTimeout));
            checkOutput("last_voter", 32'(last_voter), 32'(lastVoter));
            checkOutput("result_count", 32'(result_count), 32'(expResult));
            checkOutput("total_votes", 32'(total_votes), 32'(total));
        end
    end

    task automatic applyStimulus(input logic m, input logic w, input logic [ADDR_W-1:0] addr,
                                 input logic [4:0] id, input logic [NUM_CAND-1:0] btn,
                                 input logic [2:0] sel);
        @(negedge clk);
        mode                = m;
        write               = w;
        valid_voter_address = addr;
        valid_voter         = id;
        cand_btn            = btn;
        result_sel          = sel;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Safety net so the run always ends even if the sequence stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit, got %0d tests run, expected completion", testsRun);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        compareOn = 1'b1;
        #1;
        checkOutput("reset armed", 32'(armed), 32'd0);
        checkOutput("reset total", 32'(total_votes), 32'd0);
        checkOutput("reset last_voter", 32'(last_voter), 32'd0);
        checkOutput("reset result_count", 32'(result_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // First vote: address 3, ID 00010, candidate 1.
        applyStimulus(1'b1, 1'b1, 9'd3, 5'b00010, 4'b0000, 3'd0);
        settle();
        checkOutput("arm addr3", 32'(armed), 32'd1);
        applyStimulus(1'b1, 1'b0, 9'd0, 5'd0, 4'b0010, 3'd0);
        settle();
        checkOutput("accept addr3", 32'(vote_accepted), 32'd1);
        checkOutput("disarm after accept", 32'(armed), 32'd0);
        checkOutput("last_voter 00010", 32'(last_voter), 32'd2);
        checkOutput("total after first", 32'(total_votes), 32'd1);
        applyStimulus(1'b1, 1'b0, 9'd0, 5'd0, 4'b0000, 3'd0);
        settle();

        // Double vote from address 3.
        applyStimulus(1'b1, 1'b1, 9'd3, 5'd7, 4'b0000, 3'd0);
        settle();
        checkOutput("reject addr3", 32'(vote_rejected), 32'd1);
        checkOutput("no arm on reject", 32'(armed), 32'd0);
        applyStimulus(1'b1, 1'b0, 9'd0, 5'd0, 4'b0000, 3'd0);
        settle();
        checkOutput("reject is a pulse", 32'(vote_rejected), 32'd0);

        // Invalid press then idle keypad until timeout, then retry.
        applyStimulus(1'b1, 1'b1, 9'd5, 5'd9, 4'b0000, 3'd0);
        applyStimulus(1'b1, 1'b0, 9'd0, 5'd0, 4'b0110, 3'd0);
        for (int i = 0; i < TIMEOUT_CYCLES - 2; i++) begin
            applyStimulus(1'b1, 1'b0, 9'd0, 5'd0, 4'b0000, 3'd0);
        end
        settle();
        checkOutput("still armed before timeout", 32'(armed), 32'd1);
        checkOutput("no early timeout", 32'(timeout), 32'd0);
        applyStimulus(1'b1, 1'b0, 9'd0, 5'd0, 4'b0000, 3'd0);
        settle();
        checkOutput("timeout pulse", 32'(timeout), 32'd1);
        checkOutput("disarm on timeout", 32'(armed), 32'd0);
        checkOutput("total after timeout", 32'(total_votes), 32'd1);
        applyStimulus(1'b1, 1'b1, 9'd5, 5'd9, 4'b0000, 3'd0);
        settle();
        checkOutput("re-arm addr5", 32'(armed), 32'd1);
        applyStimulus(1'b1, 1'b0, 9'd0, 5'd0, 4'b1000, 3'd0);
        settle();
        checkOutput("accept addr5", 32'(vote_accepted), 32'd1);
        checkOutput("last_voter 9", 32'(last_voter), 32'd9);
        applyStimulus(1'b1, 1'b0, 9'd0, 5'd0, 4'b0000, 3'd0);

        // Held key across accept, writes during hold and on release ignored.
        applyStimulus(1'b1, 1'b1, 9'd7, 5'd4, 4'b0000, 3'd0);
        applyStimulus(1'b1, 1'b0, 9'd0, 5'd0, 4'b0001, 3'd0);
        applyStimulus(1'b1, 1'b1, 9'd6, 5'd11, 4'b0001, 3'd0);
        settle();
        checkOutput("write ignored while held", 32'(armed), 32'd0);
        checkOutput("held key counted once", 32'(total_votes), 32'd3);
        applyStimulus(1'b1, 1'b0, 9'd0, 5'd0, 4'b0001, 3'd0);
        applyStimulus(1'b1, 1'b1, 9'd6, 5'd11, 4'b0000, 3'd0);
        settle();
        checkOutput("write ignored on release", 32'(armed), 32'd0);
        applyStimulus(1'b1, 1'b1, 9'd6, 5'd11, 4'b0000, 3'd0);
        settle();
        checkOutput("arm addr6 after release", 32'(armed), 32'd1);
        applyStimulus(1'b1, 1'b0, 9'd0, 5'd0, 4'b0100, 3'd0);
        applyStimulus(1'b1, 1'b0, 9'd0, 5'd0, 4'b0000, 3'd0);

        // Readout of each candidate after four votes, one per candidate.
        for (int s = 0; s < NUM_CAND; s++) begin
            applyStimulus(1'b0, 1'b0, 9'd0, 5'd0, 4'b0000, 3'(s));
            settle();
            checkOutput("readout one vote each", 32'(result_count), 32'd1);
        end
        applyStimulus(1'b0, 1'b0, 9'd0, 5'd0, 4'b0000, 3'd6);
        settle();
        checkOutput("readout sel 6", 32'(result_count), 32'd0);
        checkOutput("total four", 32'(total_votes), 32'd4);

        // Drive candidate 2 into saturation with distinct voters.
        for (int i = 0; i < 258; i++) begin
            applyStimulus(1'b1, 1'b1, 9'(16 + i), 5'(i), 4'b0000, 3'd0);
            applyStimulus(1'b1, 1'b0, 9'd0, 5'd0, 4'b0100, 3'd0);
            applyStimulus(1'b1, 1'b0, 9'd0, 5'd0, 4'b0000, 3'd0);
        end
        applyStimulus(1'b0, 1'b0, 9'd0, 5'd0, 4'b0000, 3'd2);
        settle();
        checkOutput("saturated tally 2", 32'(result_count), 32'd255);
        checkOutput("saturated total", 32'(total_votes), 32'd255);
        applyStimulus(1'b0, 1'b0, 9'd0, 5'd0, 4'b0000, 3'd6);
        settle();
        checkOutput("readout sel 6 after sat", 32'(result_count), 32'd0);
        applyStimulus(1'b1, 1'b0, 9'd0, 5'd0, 4'b0000, 3'd2);
        settle();
        checkOutput("voting mode readout", 32'(result_count), 32'd0);

        // Reset while armed, then a previously used address is welcome again.
        applyStimulus(1'b1, 1'b1, 9'd4, 5'd21, 4'b0000, 3'd0);
        settle();
        checkOutput("armed before reset", 32'(armed), 32'd1);
        @(negedge clk);
        write = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("reset armed async", 32'(armed), 32'd0);
        checkOutput("reset total async", 32'(total_votes), 32'd0);
        checkOutput("reset last_voter async", 32'(last_voter), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 9'd3, 5'd13, 4'b0000, 3'd0);
        settle();
        checkOutput("re-arm addr3 after reset", 32'(armed), 32'd1);
        applyStimulus(1'b1, 1'b0, 9'd0, 5'd0, 4'b0001, 3'd0);
        settle();
        checkOutput("accept after reset", 32'(vote_accepted), 32'd1);
        checkOutput("total after reset vote", 32'(total_votes), 32'd1);
        applyStimulus(1'b1, 1'b0, 9'd0, 5'd0, 4'b0000, 3'd0);
        settle();

        @(negedge clk);
        compareOn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
